gpio_inout_mux: RTL and testbench
=================================

// Module: gpio_inout_mux
// PURPOSE
//  Register bank between the AHB-side decoders and the GPIO pins.
//  - Output half: N_OUT write registers, loaded from the bus write data. One register is
//    driven to the pin driver, chosen by the rotating counter select out_sel.
//  - Input half: N_IN capture registers, loaded from the pin bus. One register is driven
//    to the bus read path, chosen by the one-hot rdwren decode of out_sel.
//  Sits between w_addr_decoder/r_addr_decoder/wcount_addr_decoder and the gpio pin tristates.
// PARAMETERS
//  WIDTH  32  data width of every register and data port
//  N_OUT  4   number of output (write) registers, index 0..N_OUT-1
//  N_IN   4   number of input (capture) registers, index 0..N_IN-1
// PORTS
//  clk      in   1        single clock; all state updates on rising edge
//  rst      in   1        synchronous active-high reset
//  wren     in   N_OUT    per-register write enable (bit i = wren(i+1) of decoder)
//  wdata    in   WIDTH    bus write data
//  out_sel  in   3        counter select, legal 1..N_OUT (1 selects out register 0)
//  dataout  out  WIDTH    selected output register, to pin driver
//  rden     in   N_IN     per-register capture enable
//  rdwren   in   N_IN     one-hot read select from wcount_addr_decoder
//  pin_data in   WIDTH    sampled GPIO pin bus
//  rdata    out  WIDTH    selected input register, to bus read path
// BEHAVIOUR
//  - Interface: one clock (clk); reset (rst) is synchronous and active-high.
//  - Reset: on a rising clk edge with rst=1, all out_reg[i] and in_reg[i] clear to 0.
//    Reset has priority over any same-cycle wren/rden.
//    dataout and rdata are 0 while the registers hold their reset value.
//  - Write: on a rising edge with rst=0 and wren[i]=1, out_reg[i] <= wdata.
//    - Several wren bits high: every enabled register loads the same wdata.
//    - wren[i]=0: out_reg[i] holds its value.
//    - X/Z bits on wdata are stored as-is (no filtering).
//  - Capture: on a rising edge with rst=0 and rden[i]=1, in_reg[i] <= pin_data.
//    Multiple bits allowed; rden[i]=0 holds.
//  - Output select is combinational:
//    - dataout = out_reg[out_sel-1] for out_sel in 1..N_OUT.
//    - out_sel=0 or out_sel>N_OUT: dataout = 0.
//  - Read select is combinational: rdata = OR over i of (in_reg[i] & {WIDTH{rdwren[i]}}).
//    - rdwren all zero: rdata = 0.
//    - rdwren not one-hot: rdata is the bitwise OR of the selected registers (defined, no priority).
//  - Latency:
//    - A write or capture at edge k is visible on dataout/rdata immediately after edge k (1 cycle).
//    - A change on out_sel or rdwren is visible in the same cycle (0 cycles).
//  - Write-through: a write to the currently selected register shows the new value after
//    the edge, never in the same cycle.
//  - Reset mid-operation: contents are lost; selects keep working and return 0 until reloaded.
//  - No internal counter: out_sel wrap (N_OUT back to 1) is owned by the counter block.
//    This block only has to decode every out_sel value correctly.
// TESTING
//  1 Reset: rst=1 for 1 edge with wren=4'hF, wdata=32'hFFFFFFFF
//    -> all registers 0, dataout=0 for out_sel 1..4, rdata=0.
//  2 Write/select: write 32'h11111111..32'h44444444 to regs 0..3 on successive edges,
//    then sweep out_sel 1,2,3,4 -> dataout 32'h11111111,32'h22222222,32'h33333333,32'h44444444.
//  3 Illegal select: out_sel=0, 5, 7 -> dataout=0.
//    Set out_sel 4->1 (wrap) -> dataout=32'h11111111 in the same cycle.
//  4 Capture: pin_data=32'hFFFFFFEF, rden=4'b0001, one edge, rdwren=4'b0001
//    -> rdata=32'hFFFFFFEF. rdwren=4'b0010 -> rdata=0.
//  5 Simultaneous: wren=4'b0101, wdata=32'hA5A5A5A5 -> regs 0 and 2 load, regs 1 and 3 unchanged.
//    rst=1 with wren=4'hF on the same edge -> all 0.
//  6 Hold and latency: wren=0, wdata toggling for 3 edges -> dataout stable.
//    A single write appears exactly 1 edge later, not before.

Source files
------------

// File: rtl/gpio_inout_mux.sv
// GPIO register bank: write registers feeding the pin driver, capture
// registers feeding the bus read path.
module gpio_inout_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned N_IN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_OUT-1:0] wren,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       out_sel,
  output logic [WIDTH-1:0] dataout,
  input  logic [N_IN-1:0]  rden,
  input  logic [N_IN-1:0]  rdwren,
  input  logic [WIDTH-1:0] pin_data,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] out_reg [N_OUT];
  logic [WIDTH-1:0] in_reg  [N_IN];

  // Write registers: reset wins, otherwise every enabled register loads wdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_OUT; i++) out_reg[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (wren[i]) out_reg[i] <= wdata;
      end
    end
  end

  // Capture registers: reset wins, otherwise every enabled register samples the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_IN; i++) in_reg[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (rden[i]) in_reg[i] <= pin_data;
      end
    end
  end

  // Counter select is 1-based; 0 and out-of-range values drive zero.
  always_comb begin
    dataout = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (out_sel == 3'(i + 1)) dataout = out_reg[i];
    end
  end

  // AND-OR read mux so a non-one-hot select gives a defined OR of the sources.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      rdata = rdata | (in_reg[i] & {WIDTH{rdwren[i]}});
    end
  end

endmodule

// File: tb/tb_gpio_inout_mux.sv
// Directed bench for gpio_inout_mux.
module tb_gpio_inout_mux;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N_OUT = 4;
  localparam int unsigned N_IN  = 4;

  logic             clk;
  logic             rst;
  logic [N_OUT-1:0] wren;
  logic [WIDTH-1:0] wdata;
  logic [2:0]       out_sel;
  logic [WIDTH-1:0] dataout;
  logic [N_IN-1:0]  rden;
  logic [N_IN-1:0]  rdwren;
  logic [WIDTH-1:0] pin_data;
  logic [WIDTH-1:0] rdata;

  int total;
  int bad;

  gpio_inout_mux #(.WIDTH(WIDTH), .N_OUT(N_OUT), .N_IN(N_IN)) dut (
    .clk      (clk),
    .rst      (rst),
    .wren     (wren),
    .wdata    (wdata),
    .out_sel  (out_sel),
    .dataout  (dataout),
    .rden     (rden),
    .rdwren   (rdwren),
    .pin_data (pin_data),
    .rdata    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply a select and let the combinational path settle.
  task automatic sel_out(input logic [2:0] s);
    out_sel = s;
    #1;
  endtask

  task automatic sel_rd(input logic [N_IN-1:0] s);
    rdwren = s;
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_out [4];
    total = 0;
    bad   = 0;

    // 1 Reset with every enable asserted
    rst = 1'b1; wren = 4'hF; wdata = 32'hFFFF_FFFF;
    rden = 4'hF; pin_data = 32'hFFFF_FFFF; rdwren = 4'hF; out_sel = 3'd1;
    tick();
    rst = 1'b0; wren = 4'h0; rden = 4'h0;
    for (int s = 1; s <= 4; s++) begin
      sel_out(3'(s));
      check($sformatf("reset_dataout_sel%0d", s), dataout, 32'h0);
    end
    sel_rd(4'hF);
    check("reset_rdata_all", rdata, 32'h0);

    // 2 Write regs 0..3 on successive edges, then sweep the select
    exp_out[0] = 32'h1111_1111; exp_out[1] = 32'h2222_2222;
    exp_out[2] = 32'h3333_3333; exp_out[3] = 32'h4444_4444;
    for (int i = 0; i < 4; i++) begin
      wren = 4'(1 << i);
      wdata = exp_out[i];
      tick();
    end
    wren = 4'h0;
    for (int s = 1; s <= 4; s++) begin
      sel_out(3'(s));
      check($sformatf("write_sel%0d", s), dataout, exp_out[s-1]);
    end

    // 3 Illegal selects, then wrap 4 -> 1
    sel_out(3'd0); check("sel0_zero", dataout, 32'h0);
    sel_out(3'd5); check("sel5_zero", dataout, 32'h0);
    sel_out(3'd7); check("sel7_zero", dataout, 32'h0);
    sel_out(3'd4); check("wrap_from4", dataout, 32'h4444_4444);
    sel_out(3'd1); check("wrap_to1", dataout, 32'h1111_1111);

    // 4 Capture into reg 0, read it, read an empty reg
    pin_data = 32'hFFFF_FFEF; rden = 4'b0001;
    tick();
    rden = 4'b0000;
    sel_rd(4'b0001); check("capture_reg0", rdata, 32'hFFFF_FFEF);
    sel_rd(4'b0010); check("capture_reg1_empty", rdata, 32'h0);
    // rden low holds contents while the pins change
    pin_data = 32'h0000_0000;
    tick();
    sel_rd(4'b0001); check("capture_hold", rdata, 32'hFFFF_FFEF);
    // Non-one-hot read select ORs the sources
    pin_data = 32'h0000_0010; rden = 4'b0010;
    tick();
    rden = 4'b0000;
    sel_rd(4'b0010); check("capture_reg1", rdata, 32'h0000_0010);
    sel_rd(4'b0011); check("read_or_two", rdata, 32'hFFFF_FFFF);
    sel_rd(4'b0000); check("read_none", rdata, 32'h0);

    // 5 Simultaneous write to regs 0 and 2
    wren = 4'b0101; wdata = 32'hA5A5_A5A5;
    tick();
    wren = 4'h0;
    sel_out(3'd1); check("multi_reg0", dataout, 32'hA5A5_A5A5);
    sel_out(3'd2); check("multi_reg1_hold", dataout, 32'h2222_2222);
    sel_out(3'd3); check("multi_reg2", dataout, 32'hA5A5_A5A5);
    sel_out(3'd4); check("multi_reg3_hold", dataout, 32'h4444_4444);
    // Reset beats same-edge writes and captures
    rst = 1'b1; wren = 4'hF; rden = 4'hF; wdata = 32'h1234_5678; pin_data = 32'h8765_4321;
    tick();
    rst = 1'b0; wren = 4'h0; rden = 4'h0;
    for (int s = 1; s <= 4; s++) begin
      sel_out(3'(s));
      check($sformatf("rst_prio_sel%0d", s), dataout, 32'h0);
    end
    sel_rd(4'hF); check("rst_prio_rdata", rdata, 32'h0);

    // 6 Write-through latency on the selected register
    sel_out(3'd2);
    wren = 4'b0010; wdata = 32'hCAFE_F00D;
    #1;
    check("wt_before_edge", dataout, 32'h0);
    tick();
    wren = 4'h0;
    check("wt_after_edge", dataout, 32'hCAFE_F00D);
    // Hold with toggling wdata and no enables
    for (int k = 0; k < 3; k++) begin
      wdata = (k % 2 == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      tick();
      check($sformatf("hold_edge%0d", k), dataout, 32'hCAFE_F00D);
    end
    // Capture latency on the selected read register
    sel_rd(4'b0100);
    pin_data = 32'h0F0F_0F0F; rden = 4'b0100;
    #1;
    check("cap_before_edge", rdata, 32'h0);
    tick();
    rden = 4'h0;
    check("cap_after_edge", rdata, 32'h0F0F_0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
